bus_mux_arbiter: RTL and testbench
==================================

// Module: bus_mux_arbiter
// PURPOSE
//  Registered N-source, DATA_W-wide shared-bus multiplexer for the processor datapath.
//  Two modes: DIRECT (one-hot select driven by the control unit) and ARB (sources raise requests).
//  ARB uses round-robin arbitration with a bounded hold time.
//  Adds validity checking of the one-hot select and a sticky error flag.
// PARAMETERS
//  N_SRC     11   number of bus sources (>=2)
//  DATA_W    9    bus width in bits
//  MAX_HOLD  8    max consecutive ARB cycles one owner keeps the bus while others request (>=1)
// PORTS
//  Clock     in   1              rising-edge clock
//  Resetn    in   1              reset, asynchronous, active-low
//  mode      in   1              0 = DIRECT, 1 = ARB
//  sel       in   N_SRC          DIRECT one-hot select; bit i selects source i
//  req       in   N_SRC          ARB request per source
//  din       in   N_SRC*DATA_W   packed sources; source i = din[i*DATA_W +: DATA_W]
//  err_clr   in   1              clears sel_err
//  bus_out   out  DATA_W         registered bus value
//  bus_vld   out  1              bus_out carries a selected/granted source
//  grant     out  N_SRC          registered one-hot owner (all zero = none)
//  sel_err   out  1              sticky: non-one-hot, non-zero sel seen in DIRECT
// BEHAVIOUR
//  - Reset (async, Resetn=0): bus_out=0, bus_vld=0, grant=0, sel_err=0, rr_ptr=0, hold_cnt=0, state=IDLE.
//  - All outputs are registered. Latency is 1 cycle from sel/req/din to bus_out/grant.
//  - DIRECT, one-hot sel=bit i: next cycle grant=sel, bus_out=din source i, bus_vld=1.
//  - DIRECT, sel=0: next cycle grant=0, bus_out=0, bus_vld=0. No error.
//  - DIRECT, multi-hot sel: next cycle grant=0, bus_out=0, bus_vld=0, sel_err=1.
//  - sel_err stays set until err_clr=1. If set and clear occur in the same cycle, set wins.
//  - ARB FSM states: IDLE, OWN.
//    . IDLE: if any req, grant the first requester at index >= rr_ptr, wrapping modulo N_SRC;
//      go to OWN with hold_cnt=1. If no req, stay in IDLE with grant=0 and bus_vld=0.
//    . OWN, owner g: bus_out tracks din source g each cycle; bus_vld=1.
//    . OWN, req[g] dropped: rr_ptr=g+1 (wraps). In that same cycle, re-arbitrate among the other
//      requesters (no bubble). If there are none, go to IDLE; grant=0 next cycle.
//    . OWN, hold_cnt==MAX_HOLD and another source requests: forced release. rr_ptr=g+1 and the next
//      requester is granted in that cycle. With no competitor, the owner keeps the bus and
//      hold_cnt saturates.
//    . On every grant change, hold_cnt reloads to 1.
//    . req of a non-owner never preempts before MAX_HOLD.
//  - Mode change (mode differs from the previous cycle): grant=0, bus_vld=0, bus_out=0 for one
//    cycle; FSM goes to IDLE; rr_ptr is kept. The new mode takes effect the following cycle.
//    sel_err is unaffected.
//  - sel is ignored in ARB. req is ignored in DIRECT. sel_err only updates in DIRECT.
//  - Reset mid-grant: everything returns to reset values immediately; no bus_vld glitch after
//    deassertion.
//  - Invariant: grant is always one-hot or zero.
// STRUCTURE
//  - Package bus_pkg: typedef enum logic {IDLE, OWN} arb_state_t; DEFAULT_N_SRC=11, DEFAULT_DATA_W=9.
//  - Sub-module rr_pick: combinational round-robin picker.
//    Inputs: req, ptr. Outputs: one-hot pick, any.
//    Instantiated once.
//  - The top level holds the FSM, hold counter ($clog2(MAX_HOLD+1) bits), output registers and
//    the one-hot check.
// TESTING (N_SRC=11, DATA_W=9, MAX_HOLD=8)
//  1. DIRECT, sel=11'h004, src2=9'h1A5 -> next cycle bus_out=9'h1A5, bus_vld=1, grant=11'h004;
//     sel=0 -> bus_vld=0, bus_out=0.
//  2. DIRECT, sel=11'h005 -> bus_vld=0, grant=0, sel_err=1. sel_err holds through legal sels.
//     err_clr together with sel=11'h003 -> sel_err stays 1. err_clr alone -> sel_err=0.
//  3. ARB, req=11'h012 from IDLE -> grant=11'h002. Drop req[1] -> next grant=11'h010 with no
//     bus_vld gap. Drop all -> grant=0, bus_vld=0.
//  4. ARB, req[3] and req[7] held continuously -> grant alternates 3,7,3 with exactly 8 cycles
//     per owner. req[3] alone held 20 cycles -> grant never changes.
//  5. ARB, rr_ptr wrap: owner=10 releases while req=11'h401 -> grant=11'h001.
//  6. Pull Resetn low mid-OWN, asynchronously between edges -> outputs are 0 before the next
//     edge. Toggle mode mid-OWN -> one cycle with bus_vld=0 and grant=0.

Source files
------------

// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared types and defaults for the bus_mux_arbiter slice.
//   arb_state_t      : ARB-mode FSM state (IDLE / OWN)
//   DEFAULT_*        : default geometry of the shared bus
//   MODE_DIRECT/ARB  : encoding of the mode input
// -----------------------------------------------------------------------------
package bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  localparam int DEFAULT_N_SRC    = 11;
  localparam int DEFAULT_DATA_W   = 9;
  localparam int DEFAULT_MAX_HOLD = 8;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_ARB    = 1'b1;

endpackage

// File: rtl/bus_mux_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: returns the first set bit of req at an
// index >= ptr, wrapping modulo N.
//   req  in  N   request vector
//   ptr  in  PW  search start index (must be < N)
//   pick out N   one-hot winner (zero when no request)
//   any  out 1   at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N  = 11,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic          any
);

  // One extra bit so ptr + offset cannot overflow before the modulo fold.
  localparam int SW = PW + 1;

  logic [SW-1:0] w_sum;
  logic [PW-1:0] w_idx;

  always_comb begin
    pick  = '0;
    any   = 1'b0;
    w_sum = '0;
    w_idx = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, ptr} + SW'(k);
      if (w_sum >= SW'(N)) begin
        w_sum = w_sum - SW'(N);
      end
      w_idx = w_sum[PW-1:0];
      if (!any && req[w_idx]) begin
        pick[w_idx] = 1'b1;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_mux_arbiter.sv
// -----------------------------------------------------------------------------
// bus_mux_arbiter
// Registered N_SRC-source shared-bus multiplexer with two modes:
//   DIRECT : one-hot select from the control unit, multi-hot flagged in sel_err
//   ARB    : round-robin arbitration over req with a bounded hold time
// Ports
//   Clock    in   rising-edge clock
//   Resetn   in   asynchronous active-low reset
//   mode     in   0 = DIRECT, 1 = ARB
//   sel      in   DIRECT one-hot select
//   req      in   ARB requests
//   din      in   packed sources, source i = din[i*DATA_W +: DATA_W]
//   err_clr  in   clears sel_err (a same-cycle set wins)
//   bus_out  out  registered bus value
//   bus_vld  out  bus_out carries a selected/granted source
//   grant    out  registered one-hot owner (zero = none)
//   sel_err  out  sticky multi-hot select flag
// -----------------------------------------------------------------------------
module bus_mux_arbiter
  import bus_pkg::*;
#(
  parameter int N_SRC    = DEFAULT_N_SRC,
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic                    Clock,
  input  logic                    Resetn,
  input  logic                    mode,
  input  logic [N_SRC-1:0]        sel,
  input  logic [N_SRC-1:0]        req,
  input  logic [N_SRC*DATA_W-1:0] din,
  input  logic                    err_clr,
  output logic [DATA_W-1:0]       bus_out,
  output logic                    bus_vld,
  output logic [N_SRC-1:0]        grant,
  output logic                    sel_err
);

  localparam int              PW       = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int              HW       = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]   HOLD_MAX = HW'(MAX_HOLD);
  localparam logic [PW-1:0]   LAST_IDX = PW'(N_SRC - 1);

  arb_state_t          r_state;
  logic                r_mode_q;
  logic [PW-1:0]       r_rr_ptr;
  logic [HW-1:0]       r_hold;
  logic [N_SRC-1:0]    r_grant;
  logic [DATA_W-1:0]   r_bus_out;
  logic                r_bus_vld;
  logic                r_sel_err;

  logic                w_mode_chg;
  logic                w_sel_zero;
  logic                w_sel_multi;
  logic                w_err_set;
  logic                w_own_req;
  logic                w_release;
  logic [PW-1:0]       w_own_idx;
  logic [PW-1:0]       w_own_inc;
  logic [PW-1:0]       w_pick_ptr;
  logic [N_SRC-1:0]    w_pick_req;
  logic [N_SRC-1:0]    w_pick;
  logic                w_pick_any;

  function automatic logic [DATA_W-1:0] mux_src(input logic [N_SRC-1:0]        oh,
                                                input logic [N_SRC*DATA_W-1:0] d);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (oh[i]) v = v | d[i*DATA_W +: DATA_W];
    end
    return v;
  endfunction

  assign w_mode_chg  = (mode != r_mode_q);
  assign w_sel_zero  = (sel == '0);
  // Clearing the lowest set bit leaves something only if more than one bit was set.
  assign w_sel_multi = |(sel & (sel - N_SRC'(1)));
  assign w_err_set   = !w_mode_chg && (mode == MODE_DIRECT) && w_sel_multi;

  always_comb begin
    w_own_idx = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (r_grant[i]) w_own_idx = PW'(i);
    end
  end

  assign w_own_inc  = (w_own_idx == LAST_IDX) ? '0 : w_own_idx + PW'(1);
  assign w_own_req  = |(req & r_grant);
  // The current owner is masked out so a forced release always hands over.
  assign w_pick_req = req & ~r_grant;
  // When releasing, search starts just past the owner, i.e. at the new rr_ptr.
  assign w_pick_ptr = (r_state == OWN) ? w_own_inc : r_rr_ptr;
  assign w_release  = (r_state == OWN) &&
                      (!w_own_req || ((r_hold == HOLD_MAX) && w_pick_any));

  rr_pick #(
    .N  (N_SRC),
    .PW (PW)
  ) u_rr_pick (
    .req  (w_pick_req),
    .ptr  (w_pick_ptr),
    .pick (w_pick),
    .any  (w_pick_any)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state   <= IDLE;
      r_mode_q  <= MODE_DIRECT;
      r_rr_ptr  <= '0;
      r_hold    <= '0;
      r_grant   <= '0;
      r_bus_out <= '0;
      r_bus_vld <= 1'b0;
      r_sel_err <= 1'b0;
    end else begin
      r_mode_q <= mode;

      if (w_err_set) begin
        r_sel_err <= 1'b1;
      end else if (err_clr) begin
        r_sel_err <= 1'b0;
      end

      if (w_mode_chg) begin
        // One dead cycle on any mode switch; rr_ptr survives it.
        r_state   <= IDLE;
        r_hold    <= '0;
        r_grant   <= '0;
        r_bus_out <= '0;
        r_bus_vld <= 1'b0;
      end else if (mode == MODE_DIRECT) begin
        r_state <= IDLE;
        r_hold  <= '0;
        if (w_sel_zero || w_sel_multi) begin
          r_grant   <= '0;
          r_bus_out <= '0;
          r_bus_vld <= 1'b0;
        end else begin
          r_grant   <= sel;
          r_bus_out <= mux_src(sel, din);
          r_bus_vld <= 1'b1;
        end
      end else begin
        case (r_state)
          IDLE: begin
            if (w_pick_any) begin
              r_state   <= OWN;
              r_hold    <= HW'(1);
              r_grant   <= w_pick;
              r_bus_out <= mux_src(w_pick, din);
              r_bus_vld <= 1'b1;
            end else begin
              r_grant   <= '0;
              r_bus_out <= '0;
              r_bus_vld <= 1'b0;
            end
          end
          OWN: begin
            if (w_release) begin
              r_rr_ptr <= w_own_inc;
              if (w_pick_any) begin
                r_state   <= OWN;
                r_hold    <= HW'(1);
                r_grant   <= w_pick;
                r_bus_out <= mux_src(w_pick, din);
                r_bus_vld <= 1'b1;
              end else begin
                r_state   <= IDLE;
                r_hold    <= '0;
                r_grant   <= '0;
                r_bus_out <= '0;
                r_bus_vld <= 1'b0;
              end
            end else begin
              r_bus_out <= mux_src(r_grant, din);
              r_bus_vld <= 1'b1;
              if (r_hold != HOLD_MAX) begin
                r_hold <= r_hold + HW'(1);
              end
            end
          end
          default: begin
            r_state   <= IDLE;
            r_grant   <= '0;
            r_bus_out <= '0;
            r_bus_vld <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus_out = r_bus_out;
  assign bus_vld = r_bus_vld;
  assign grant   = r_grant;
  assign sel_err = r_sel_err;

endmodule

// File: tb/tb_bus_mux_arbiter.sv
module tb_bus_mux_arbiter;

  localparam int N  = 11;
  localparam int W  = 9;
  localparam int MH = 8;

  logic           Clock = 1'b0;
  logic           Resetn;
  logic           mode;
  logic [N-1:0]   sel;
  logic [N-1:0]   req;
  logic [N*W-1:0] din;
  logic           err_clr;
  logic [W-1:0]   bus_out;
  logic           bus_vld;
  logic [N-1:0]   grant;
  logic           sel_err;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  bus_mux_arbiter #(
    .N_SRC    (N),
    .DATA_W   (W),
    .MAX_HOLD (MH)
  ) dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .mode    (mode),
    .sel     (sel),
    .req     (req),
    .din     (din),
    .err_clr (err_clr),
    .bus_out (bus_out),
    .bus_vld (bus_vld),
    .grant   (grant),
    .sel_err (sel_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk4(input string tag, input logic [W-1:0] e_out, input logic e_vld,
                      input logic [N-1:0] e_grant, input logic e_err);
    chk({tag, ".bus_out"}, 32'(bus_out), 32'(e_out));
    chk({tag, ".bus_vld"}, 32'(bus_vld), 32'(e_vld));
    chk({tag, ".grant"},   32'(grant),   32'(e_grant));
    chk({tag, ".sel_err"}, 32'(sel_err), 32'(e_err));
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Resetn = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    Resetn = 1'b1;
  endtask

  function automatic logic [W-1:0] srcv(input logic [N*W-1:0] d, input int i);
    return d[i*W +: W];
  endfunction

  function automatic logic [N*W-1:0] din_pattern();
    logic [N*W-1:0] d;
    for (int i = 0; i < N; i++) d[i*W +: W] = W'(i * 37 + 17);
    d[2*W +: W] = 9'h1A5;
    return d;
  endfunction

  // ---------------- behavioural reference model ----------------
  int           m_prev;
  int           m_own;   // owning source index, -1 = none
  int           m_ptr;
  int           m_hold;
  logic         m_err;
  logic [W-1:0] e_out;
  logic         e_vld;
  logic [N-1:0] e_grant;

  task automatic m_reset();
    m_prev = 0; m_own = -1; m_ptr = 0; m_hold = 0; m_err = 1'b0;
    e_out = '0; e_vld = 1'b0; e_grant = '0;
  endtask

  function automatic int find_req(input logic [N-1:0] r, input int start, input int skip);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (start + k) % N;
      if (i != skip && r[i]) return i;
    end
    return -1;
  endfunction

  task automatic m_step();
    int   ones;
    logic set;
    logic [N-1:0] one;
    ones = $countones(sel);
    set  = 1'b0;
    one  = 1;
    if (int'(mode) != m_prev) begin
      m_own = -1; m_hold = 0;
    end else if (mode == 1'b0) begin
      m_own = -1; m_hold = 0;
      if (ones == 1) m_own = find_req(sel, 0, -1);
      if (ones > 1) set = 1'b1;
    end else if (m_own < 0) begin
      m_own = find_req(req, m_ptr, -1);
      m_hold = (m_own >= 0) ? 1 : 0;
    end else if (!req[m_own] || (m_hold == MH && find_req(req, 0, m_own) >= 0)) begin
      m_ptr  = (m_own + 1) % N;
      m_own  = find_req(req, m_ptr, m_own);
      m_hold = (m_own >= 0) ? 1 : 0;
    end else if (m_hold < MH) begin
      m_hold++;
    end
    if (set) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
    m_prev  = int'(mode);
    e_vld   = (m_own >= 0);
    e_grant = (m_own >= 0) ? (one << m_own) : '0;
    e_out   = (m_own >= 0) ? din[m_own*W +: W] : '0;
  endtask

  // ---------------- DIRECT-mode vector table ----------------
  typedef struct {
    logic [N-1:0] sel;
    logic         clr;
    logic [W-1:0] e_out;
    logic         e_vld;
    logic [N-1:0] e_grant;
    logic         e_err;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [N*W-1:0] dp;
    int n;

    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N*W-1:0] dp;
    int n;

    dp = din_pattern();
    tbl[0] = '{11'h004, 1'b0, 9'h1A5,       1'b1, 11'h004, 1'b0};
    tbl[1] = '{11'h000, 1'b0, 9'h000,       1'b0, 11'h000, 1'b0};
    tbl[2] = '{11'h001, 1'b0, srcv(dp, 0),  1'b1, 11'h001, 1'b0};
    tbl[3] = '{11'h400, 1'b0, srcv(dp, 10), 1'b1, 11'h400, 1'b0};
    tbl[4] = '{11'h005, 1'b0, 9'h000,       1'b0, 11'h000, 1'b1};
    tbl[5] = '{11'h008, 1'b0, srcv(dp, 3),  1'b1, 11'h008, 1'b1};
    tbl[6] = '{11'h003, 1'b1, 9'h000,       1'b0, 11'h000, 1'b1};
    tbl[7] = '{11'h000, 1'b1, 9'h000,       1'b0, 11'h000, 1'b0};
    tbl[8] = '{11'h010, 1'b0, srcv(dp, 4),  1'b1, 11'h010, 1'b0};

    mode = 1'b0; sel = '0; req = '0; din = dp; err_clr = 1'b0;
    do_reset();
    chk4("reset", '0, 1'b0, '0, 1'b0);

    for (int v = 0; v < 9; v++) begin
      sel = tbl[v].sel; err_clr = tbl[v].clr;
      tick();
      chk4($sformatf("direct[%0d]", v), tbl[v].e_out, tbl[v].e_vld, tbl[v].e_grant, tbl[v].e_err);
    end
    sel = '0; err_clr = 1'b0;

    // ARB basic grant, no-bubble handoff, drop all
    mode = 1'b1;
    tick();
    chk4("arb_mchg", '0, 1'b0, '0, 1'b0);
    req = 11'h012;
    tick();
    chk4("arb_first", srcv(dp, 1), 1'b1, 11'h002, 1'b0);
    req = 11'h010;
    tick();
    chk4("arb_handoff", srcv(dp, 4), 1'b1, 11'h010, 1'b0);
    req = 11'h000;
    tick();
    chk4("arb_none", '0, 1'b0, '0, 1'b0);

    // Async reset mid-OWN (rr_ptr is 5 here, so the search wraps to source 1)
    req = 11'h012;
    tick();
    chk4("arb_wrap", srcv(dp, 1), 1'b1, 11'h002, 1'b0);
    #2;
    Resetn = 1'b0;
    #1;
    chk4("async_rst", '0, 1'b0, '0, 1'b0);
    @(posedge Clock);
    #1;
    Resetn = 1'b1;
    req = '0;
    tick();
    chk4("post_rst", '0, 1'b0, '0, 1'b0);

    // Two competitors: 8 cycles per owner, alternating 3,7,3
    req = 11'h088;
    for (int c = 0; c < 24; c++) begin
      tick();
      chk($sformatf("rr_alt[%0d]", c), 32'(grant), ((c / 8) % 2 == 0) ? 32'h008 : 32'h080);
    end
    // No competitor: owner keeps the bus, hold saturates
    req = 11'h008;
    for (int c = 0; c < 20; c++) begin
      tick();
      chk($sformatf("solo[%0d]", c), 32'(grant), 32'h008);
    end

    // Owner 10, forced release wraps to source 0
    req = 11'h400;
    tick();
    chk("own10", 32'(grant), 32'h400);
    req = 11'h401;
    n = 0;
    do begin
      tick();
      n++;
    end while (grant == 11'h400 && n < 12);
    chk("own10_hold_len", 32'(n), 32'(MH));
    chk("wrap_grant", 32'(grant), 32'h001);
    chk("wrap_out", 32'(bus_out), 32'(srcv(dp, 0)));

    // Mode toggle mid-OWN: one dead cycle, then DIRECT takes effect
    mode = 1'b0; sel = 11'h002; req = '0;
    tick();
    chk4("toggle_dead", '0, 1'b0, '0, 1'b0);
    tick();
    chk4("toggle_direct", srcv(dp, 1), 1'b1, 11'h002, 1'b0);

    // Randomised run against the reference model
    mode = 1'b0; sel = '0; req = '0; err_clr = 1'b0;
    do_reset();
    m_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 24) == 0) mode = ~mode;
      case ($urandom_range(0, 3))
        0:       sel = '0;
        1, 2:    sel = N'(1) << $urandom_range(0, N - 1);
        default: sel = N'($urandom);
      endcase
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 9) == 0) req[b] = ~req[b];
        din[b*W +: W] = W'($urandom);
      end
      err_clr = ($urandom_range(0, 15) == 0);
      m_step();
      tick();
      chk4($sformatf("rand[%0d]", c), e_out, e_vld, e_grant, m_err);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Grant must always be one-hot or zero.
  always @(negedge Clock) begin
    if (Resetn === 1'b1 && !$onehot0(grant)) begin
      errors++;
      $display("FAIL grant_onehot: got %0h required one-hot or zero", grant);
    end
  end

endmodule
